// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch FSM state type and default PC width.
package fetch_pkg;
   localparam int PSIZE_DEF = 6;
   typedef enum logic [1:0] {RUN, WAIT_PRESS, WAIT_RELEASE} fetch_state_t;
endpackage

// File: rtl/btn_sync.sv
// btn_sync: two-flop synchroniser for the raw asynchronous user button.
module btn_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic s1_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q <= 1'b0;
         q    <= 1'b0;
      end else begin
         s1_q <= d;
         q    <= s1_q;
      end
   end
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: program counter with LOAD button handshake and NOP halt.
module pc_fetch
   import fetch_pkg::*;
#(
   parameter int PSIZE     = PSIZE_DEF,
   parameter int PROG_LAST = 2**PSIZE-1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             PCincr,
   input  logic             is_load,
   input  logic             btn,
   output logic [PSIZE-1:0] pc,
   output logic             load_we,
   output logic             halted
);
   fetch_state_t state_q, state_d;
   logic [PSIZE-1:0] pc_q, pc_d, pc_inc;
   logic we_q, we_d, btn_s;
   btn_sync u_sync (.clk(clk), .reset(reset), .d(btn), .q(btn_s));
   assign pc_inc = (pc_q == PSIZE'(PROG_LAST)) ? '0 : pc_q + PSIZE'(1);
   // is_load wins over PCincr so an illegal encoding still waits for the button
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      we_d    = 1'b0;
      case (state_q)
         RUN: begin
            if (is_load) state_d = WAIT_PRESS;
            else if (PCincr) pc_d = pc_inc;
         end
         WAIT_PRESS: begin
            if (btn_s) begin
               state_d = WAIT_RELEASE;
               we_d    = 1'b1;
            end
         end
         WAIT_RELEASE: begin
            if (!btn_s) begin
               state_d = RUN;
               pc_d    = pc_inc;
            end
         end
         default: state_d = RUN;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
         pc_q    <= '0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         we_q    <= we_d;
      end
   end
   assign pc      = pc_q;
   assign load_we = we_q;
   assign halted  = (state_q == RUN) && !PCincr && !is_load;
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: table-driven vectors plus directed LOAD, NOP, reset and wrap sequences.
module tb_pc_fetch;
   logic clk = 1'b0, reset = 1'b1, PCincr = 1'b0, is_load = 1'b0, btn = 1'b0;
   logic [5:0] pc;
   logic load_we, halted;
   logic reset2 = 1'b1;
   logic [2:0] pc2;
   logic we2, halted2;
   int n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;
   pc_fetch dut (
      .clk(clk), .reset(reset), .PCincr(PCincr), .is_load(is_load), .btn(btn),
      .pc(pc), .load_we(load_we), .halted(halted)
   );
   pc_fetch #(.PSIZE(3), .PROG_LAST(5)) dut2 (
      .clk(clk), .reset(reset2), .PCincr(1'b1), .is_load(1'b0), .btn(1'b0),
      .pc(pc2), .load_we(we2), .halted(halted2)
   );
   typedef struct {
      int   n;
      logic rst, inc, ld, b;
      int   pc, we, halt;
   } vec_t;
   vec_t tbl[$];
   function automatic vec_t v(int n, bit rst, bit inc, bit ld, bit b, int p, int w, int h);
      vec_t e;
      e.n = n; e.rst = rst; e.inc = inc; e.ld = ld; e.b = b;
      e.pc = p; e.we = w; e.halt = h;
      return e;
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   initial begin
      int wc;
      // n, rst, inc, ld, btn -> pc, load_we, halted
      tbl.push_back(v(1, 1, 1, 0, 0, 0, 0, 0));
      tbl.push_back(v(1, 0, 1, 0, 0, 1, 0, 0));
      tbl.push_back(v(1, 0, 1, 0, 0, 2, 0, 0));
      tbl.push_back(v(1, 0, 1, 0, 0, 3, 0, 0));
      tbl.push_back(v(1, 0, 1, 0, 0, 4, 0, 0));
      tbl.push_back(v(1, 0, 1, 0, 0, 5, 0, 0));
      tbl.push_back(v(1, 1, 1, 0, 0, 0, 0, 0));
      tbl.push_back(v(1, 0, 1, 0, 0, 1, 0, 0));
      tbl.push_back(v(1, 0, 1, 0, 0, 2, 0, 0));
      tbl.push_back(v(1, 0, 1, 0, 0, 3, 0, 0));
      tbl.push_back(v(10, 0, 0, 1, 0, 3, 0, 0));
      tbl.push_back(v(2, 0, 0, 1, 1, 3, 0, 0));
      tbl.push_back(v(1, 0, 0, 1, 1, 3, 1, 0));
      tbl.push_back(v(1, 0, 0, 1, 1, 3, 0, 0));
      tbl.push_back(v(2, 0, 0, 1, 0, 3, 0, 0));
      tbl.push_back(v(1, 0, 0, 1, 0, 4, 0, 0));
      tbl.push_back(v(1, 0, 1, 0, 0, 5, 0, 0));
      foreach (tbl[i]) begin
         for (int r = 0; r < tbl[i].n; r++) begin
            reset = tbl[i].rst; PCincr = tbl[i].inc; is_load = tbl[i].ld; btn = tbl[i].b;
            tick;
            chk($sformatf("vec%0d.%0d pc", i, r), pc, tbl[i].pc);
            chk($sformatf("vec%0d.%0d load_we", i, r), load_we, tbl[i].we);
            chk($sformatf("vec%0d.%0d halted", i, r), halted, tbl[i].halt);
         end
      end
      // LOAD entered with the button already held
      btn = 1'b1; PCincr = 1'b1; is_load = 1'b0;
      tick;
      tick;
      chk("held_pre_pc", pc, 7);
      PCincr = 1'b0; is_load = 1'b1;
      tick;
      chk("held_enter_pc", pc, 7);
      chk("held_enter_we", load_we, 0);
      tick;
      chk("held_first_we", load_we, 1);
      wc = 1;
      repeat (6) begin
         tick;
         wc += int'(load_we);
         chk("held_hold_pc", pc, 7);
      end
      btn = 1'b0;
      tick;
      wc += int'(load_we);
      tick;
      wc += int'(load_we);
      chk("held_release_pc", pc, 7);
      tick;
      wc += int'(load_we);
      chk("held_advance_pc", pc, 8);
      chk("held_we_count", wc, 1);
      // NOP at pc=2 halts and ignores the button
      PCincr = 1'b1; is_load = 1'b0; reset = 1'b1;
      tick;
      reset = 1'b0;
      tick;
      tick;
      chk("nop_pc_pre", pc, 2);
      PCincr = 1'b0;
      #1;
      chk("nop_halted_now", halted, 1);
      for (int i = 0; i < 20; i++) begin
         btn = i[1];
         tick;
         chk($sformatf("nop%0d pc", i), pc, 2);
         chk($sformatf("nop%0d we", i), load_we, 0);
         chk($sformatf("nop%0d halted", i), halted, 1);
      end
      // reset during WAIT_RELEASE abandons the LOAD
      btn = 1'b0; PCincr = 1'b1; reset = 1'b1;
      tick;
      reset = 1'b0;
      tick;
      chk("rst_pre_pc", pc, 1);
      PCincr = 1'b0; is_load = 1'b1;
      tick;
      btn = 1'b1;
      tick;
      tick;
      tick;
      chk("rst_load_we", load_we, 1);
      tick;
      chk("rst_wr_we", load_we, 0);
      chk("rst_wr_pc", pc, 1);
      reset = 1'b1;
      #1;
      chk("rst_async_pc", pc, 0);
      chk("rst_async_we", load_we, 0);
      #2;
      reset = 1'b0; PCincr = 1'b1; is_load = 1'b0;
      wc = 0;
      for (int i = 1; i <= 4; i++) begin
         tick;
         wc += int'(load_we);
         chk($sformatf("rst_run%0d pc", i), pc, i);
      end
      chk("rst_no_extra_we", wc, 0);
      // wrap on the PSIZE=3, PROG_LAST=5 instance
      reset2 = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick;
         chk("wrap_range", pc2 <= 3'd5, 1);
         if (pc2 == 3'd4) break;
      end
      chk("wrap_reach4", pc2, 4);
      tick;
      chk("wrap_5", pc2, 5);
      tick;
      chk("wrap_0", pc2, 0);
      tick;
      chk("wrap_1", pc2, 1);
      chk("wrap_we", we2, 0);
      chk("wrap_halted", halted2, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter PSIZE, default 6: program counter width.
REQ-002 SHALL have parameter PROG_LAST, default 2**PSIZE-1: last valid program address; the PC wraps after this address.
REQ-003 SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have the port PCincr, input, 1 bit: advance request from the decoder for the current instruction.
REQ-006 SHALL have the port is_load, input, 1 bit: the current instruction is LOAD (switch-wait instruction).
REQ-007 SHALL have the port btn, input, 1 bit: raw, asynchronous user advance button (switch 8).
REQ-008 SHALL have the port pc, output, PSIZE bits: instruction ROM address, registered.
REQ-009 SHALL have the port load_we, output, 1 bit: single-cycle register-file write strobe for a LOAD.
REQ-010 SHALL have the port halted, output, 1 bit: high while the PC is frozen on a non-advancing, non-LOAD instruction.

Function
REQ-011 SHALL use an FSM with states RUN, WAIT_PRESS and WAIT_RELEASE.
REQ-012 SHALL, in RUN with PCincr=1, load pc with pc+1 on the next edge, giving one-instruction-per-cycle throughput.
REQ-013 SHALL wrap pc from PROG_LAST to 0, and SHALL never present an address above PROG_LAST.
REQ-014 SHALL, in RUN with PCincr=0 and is_load=1, hold pc and move to WAIT_PRESS.
REQ-015 SHALL, in RUN with PCincr=0 and is_load=0 (NOP), hold pc, stay in RUN and drive halted=1 combinationally; halting is permanent until reset.
REQ-016 SHALL, in WAIT_PRESS, hold pc until the synchronised button (btn_s) is seen at 1.
REQ-017 SHALL, on that btn_s=1 cycle, assert load_we for exactly that one cycle and move to WAIT_RELEASE.
REQ-018 SHALL, in WAIT_RELEASE, hold pc with load_we=0 until btn_s=0.
REQ-019 SHALL, on the btn_s=0 cycle, load pc with pc+1 (with wrap) and return to RUN.
REQ-020 SHALL, if btn is already held on entering WAIT_PRESS, perform the LOAD immediately; a single press SHALL satisfy exactly one LOAD.
REQ-021 SHALL ignore PCincr and is_load outside RUN.
REQ-022 SHALL give priority to is_load over PCincr if both are 1 (illegal encoding): the block waits.
REQ-023 SHALL have a button latency of 2 clk cycles (btn to btn_s), plus 1 cycle to load_we.
REQ-024 SHALL make load_we a registered decode of the state and btn_s, glitch-free, and SHALL never assert it in RUN.

Reset
REQ-025 SHALL, while reset=1, asynchronously force pc=0, state=RUN, load_we=0 and clear the synchroniser flops.
REQ-026 SHALL, on reset asserted mid-WAIT_PRESS or mid-WAIT_RELEASE, abandon the pending LOAD (no load_we) and restart fetch at address 0.
REQ-027 SHALL report halted=0 out of reset unless the instruction at address 0 is NOP.

Structure
REQ-028 SHALL place the state enum (fetch_state_t) and the default PSIZE constant in the shared package fetch_pkg.
REQ-029 SHALL implement the two-flop synchroniser as the sub-module btn_sync (clk, reset, d, q).
REQ-030 SHALL contain no ROM inside pc_fetch; the ROM remains external and combinational on pc.

Verification
REQ-031 SHALL verify reset plus 5 cycles of PCincr=1: pc goes 0,1,2,3,4,5 and load_we never asserts.
REQ-032 SHALL verify wrap with PSIZE=3 and PROG_LAST=5 under constant PCincr=1: pc goes 4,5,0,1.
REQ-033 SHALL verify a LOAD at pc=3 with btn low for 10 cycles, then btn high 4 cycles, then low: pc holds 3 throughout, load_we pulses once 3 cycles after btn rises, and pc becomes 4 three cycles after btn falls.
REQ-034 SHALL verify a LOAD entered with btn already high: exactly one load_we, and no advance until btn is released.
REQ-035 SHALL verify NOP at pc=2: halted=1, pc stays 2 for 20 cycles and btn is ignored.
REQ-036 SHALL verify reset pulsed during WAIT_RELEASE: pc returns to 0 immediately, state is RUN and no extra load_we occurs.
